// File: rtl/floo_axis_noc_bridge_credit.sv
// Purpose: bridges NumChan credit-controlled NoC channels onto one AXIS pair, each beat carrying a flit and/or a credit return.
// Latency: TX flit -> axis_out valid 1 cycle (registered 2-entry FIFO); axis_in -> noc_out valid 1 cycle (per-channel RX FIFOs).
// Backpressure: TX stalls on zero credit or a full output FIFO; axis_in never stalls, RX overflow drops the beat and sets err_o.

// Generic synchronous FIFO with registered read data; a push to a full FIFO is ignored.
module floo_axis_noc_bridge_credit_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_vld,
  input  logic [Width-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [Width-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == DepthCnt);
  assign empty   = (cnt == '0);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_rdy && !empty;
  assign pop_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module floo_axis_noc_bridge_credit #(
  parameter  int unsigned NumChan   = 2,
  parameter  int unsigned DataWidth = 64,
  parameter  int unsigned RxDepth   = 4,
  localparam int unsigned IdxW      = (NumChan > 1) ? $clog2(NumChan) : 1,
  localparam int unsigned CntW      = $clog2(RxDepth + 1),
  localparam int unsigned BeatW     = 2 + 2 * IdxW + DataWidth
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumChan-1:0]             noc_in_valid_i,
  output logic [NumChan-1:0]             noc_in_ready_o,
  input  logic [NumChan*DataWidth-1:0]   noc_in_data_i,
  output logic [NumChan-1:0]             noc_out_valid_o,
  input  logic [NumChan-1:0]             noc_out_ready_i,
  output logic [NumChan*DataWidth-1:0]   noc_out_data_o,
  output logic                           axis_out_tvalid_o,
  input  logic                           axis_out_tready_i,
  output logic [BeatW-1:0]               axis_out_tdata_o,
  input  logic                           axis_in_tvalid_i,
  output logic                           axis_in_tready_o,
  input  logic [BeatW-1:0]               axis_in_tdata_i,
  output logic                           err_o
);
  localparam logic [CntW-1:0] MaxCnt = CntW'(RxDepth);

  typedef struct packed {
    logic                 crd_vld;
    logic [IdxW-1:0]      crd_idx;
    logic                 dat_vld;
    logic [IdxW-1:0]      dat_idx;
    logic [DataWidth-1:0] data;
  } beat_t;

  logic [NumChan-1:0][CntW-1:0] credit_q;
  logic [NumChan-1:0][CntW-1:0] pend_q;
  logic [IdxW-1:0]              rr_q;
  logic                         err_q;

  logic [DataWidth-1:0] in_dat [NumChan];
  logic [NumChan-1:0]   eligible;
  logic                 gnt_vld;
  logic [IdxW-1:0]      gnt_idx;
  logic                 crd_any;
  logic [IdxW-1:0]      crd_sel;
  beat_t                tx_beat;
  beat_t                rx_beat;
  logic                 out_full;
  logic                 out_empty;
  logic                 out_push;
  logic                 rx_acc;
  logic [NumChan-1:0]   rx_full;
  logic [NumChan-1:0]   rx_empty;
  logic [NumChan-1:0]   rx_push;
  logic [NumChan-1:0]   rx_pop;
  logic [NumChan-1:0]   rx_drop;
  logic [NumChan-1:0]   cred_inc;
  logic [NumChan-1:0]   cred_dec;
  logic [NumChan-1:0]   crd_ovf;
  logic [NumChan-1:0]   pend_dec;

  assign rx_beat          = axis_in_tdata_i;
  assign rx_acc           = axis_in_tvalid_i && rst_ni;
  assign axis_in_tready_o = rst_ni;
  assign err_o            = err_q;

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    assign in_dat[c]       = noc_in_data_i[c*DataWidth +: DataWidth];
    assign eligible[c]     = noc_in_valid_i[c] && (credit_q[c] != '0);
    assign cred_dec[c]     = out_push && gnt_vld && (gnt_idx == IdxW'(c));
    assign cred_inc[c]     = rx_acc && rx_beat.crd_vld && (rx_beat.crd_idx == IdxW'(c));
    assign crd_ovf[c]      = cred_inc[c] && !cred_dec[c] && (credit_q[c] == MaxCnt);
    assign pend_dec[c]     = out_push && crd_any && (crd_sel == IdxW'(c));
    assign rx_push[c]      = rx_acc && rx_beat.dat_vld && (rx_beat.dat_idx == IdxW'(c));
    assign rx_drop[c]      = rx_push[c] && rx_full[c];
    assign rx_pop[c]       = noc_out_ready_i[c] && !rx_empty[c];
    assign noc_out_valid_o[c] = rst_ni && !rx_empty[c];

    floo_axis_noc_bridge_credit_fifo #(
      .Width (DataWidth),
      .Depth (RxDepth)
    ) i_rx_fifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .push_vld (rx_push[c]),
      .push_dat (rx_beat.data),
      .pop_rdy  (noc_out_ready_i[c]),
      .pop_dat  (noc_out_data_o[c*DataWidth +: DataWidth]),
      .full     (rx_full[c]),
      .empty    (rx_empty[c])
    );
  end

  // Round-robin grant among eligible channels, starting from rr_q.
  always_comb begin
    logic [IdxW-1:0] c;
    c       = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NumChan; i++) begin
      c = IdxW'((int'(rr_q) + i) % int'(NumChan));
      if (!gnt_vld && eligible[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = c;
      end
    end
  end

  // Lowest-index channel with credits waiting to be returned.
  always_comb begin
    crd_any = 1'b0;
    crd_sel = '0;
    for (int i = NumChan - 1; i >= 0; i--) begin
      if (pend_q[i] != '0) begin
        crd_any = 1'b1;
        crd_sel = IdxW'(i);
      end
    end
  end

  // Outgoing beat assembly; unused index and data fields stay zero.
  always_comb begin
    tx_beat         = '0;
    tx_beat.crd_vld = crd_any;
    tx_beat.crd_idx = crd_sel;
    tx_beat.dat_vld = gnt_vld;
    tx_beat.dat_idx = gnt_idx;
    if (gnt_vld) tx_beat.data = in_dat[gnt_idx];
  end

  assign out_push = rst_ni && !out_full && (gnt_vld || crd_any);

  // Only the granted channel sees ready, and only when the beat is really pushed.
  always_comb begin
    noc_in_ready_o = '0;
    if (out_push && gnt_vld) noc_in_ready_o[gnt_idx] = 1'b1;
  end

  floo_axis_noc_bridge_credit_fifo #(
    .Width (BeatW),
    .Depth (2)
  ) i_out_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_vld (out_push),
    .push_dat (tx_beat),
    .pop_rdy  (axis_out_tready_i),
    .pop_dat  (axis_out_tdata_o),
    .full     (out_full),
    .empty    (out_empty)
  );

  assign axis_out_tvalid_o = rst_ni && !out_empty;

  // Credit, pending-return, arbitration pointer and sticky error state; same-cycle inc/dec nets out.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumChan; i++) begin
        credit_q[i] <= MaxCnt;
        pend_q[i]   <= '0;
      end
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NumChan; i++) begin
        if (cred_inc[i] && !cred_dec[i]) begin
          if (credit_q[i] != MaxCnt) credit_q[i] <= credit_q[i] + CntW'(1);
        end else if (cred_dec[i] && !cred_inc[i]) begin
          credit_q[i] <= credit_q[i] - CntW'(1);
        end
        if (rx_pop[i] && !pend_dec[i]) begin
          pend_q[i] <= pend_q[i] + CntW'(1);
        end else if (pend_dec[i] && !rx_pop[i]) begin
          pend_q[i] <= pend_q[i] - CntW'(1);
        end
      end
      if (out_push && gnt_vld) begin
        rr_q <= (gnt_idx == IdxW'(NumChan - 1)) ? '0 : gnt_idx + IdxW'(1);
      end
      if ((|crd_ovf) || (|rx_drop)) err_q <= 1'b1;
    end
  end
endmodule

// File: doc/floo_axis_noc_bridge_credit.md
FLOO_AXIS_NOC_BRIDGE_CREDIT -- requirements
Module: floo_axis_noc_bridge_credit

Interface
REQ-001 SHALL have parameter NumChan, default 2: number of NoC channels per direction, at least 2.
REQ-002 SHALL have parameter DataWidth, default 64: flit payload width in bits.
REQ-003 SHALL have parameter RxDepth, default 4: per-channel receive FIFO depth, at least 2; also the initial credit count.
REQ-004 SHALL derive IdxW = max(1, clog2(NumChan)), CntW = clog2(RxDepth+1) and BeatW = 2 + 2*IdxW + DataWidth.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port noc_in_valid_i, input, NumChan bits: per-channel flit valid from the NoC.
REQ-008 SHALL have port noc_in_ready_o, output, NumChan bits: per-channel flit ready to the NoC.
REQ-009 SHALL have port noc_in_data_i, input, NumChan*DataWidth bits: channel c occupies bits [c*DataWidth +: DataWidth].
REQ-010 SHALL have ports noc_out_valid_o (output), noc_out_ready_i (input) and noc_out_data_o (output), with the same widths and packing as REQ-007 to REQ-009: received flits to the NoC.
REQ-011 SHALL have ports axis_out_tvalid_o (output, 1 bit), axis_out_tready_i (input, 1 bit) and axis_out_tdata_o (output, BeatW bits): outgoing AXIS beats.
REQ-012 SHALL have ports axis_in_tvalid_i (input, 1 bit), axis_in_tready_o (output, 1 bit) and axis_in_tdata_i (input, BeatW bits): incoming AXIS beats.
REQ-013 SHALL have port err_o, output, 1 bit: sticky flag for a receive FIFO overflow or a credit overflow.
REQ-014 SHALL pack every beat MSB to LSB as {crd_vld, crd_idx[IdxW], dat_vld, dat_idx[IdxW], data[DataWidth]}.

Function
REQ-015 SHALL keep one credit counter per channel, CntW bits wide, reset to RxDepth.
REQ-016 SHALL treat TX channel c as eligible only when noc_in_valid_i[c]=1 and credit[c]>0.
REQ-017 SHALL grant one eligible channel per cycle, round-robin; after a grant to channel c the highest priority passes to c+1 mod NumChan.
REQ-018 SHALL assert noc_in_ready_o[c] only for the granted channel, and only when the output stage can accept a beat.
REQ-019 SHALL use a 2-entry output FIFO; a beat accepted at cycle t is valid on axis_out at t+1 if the FIFO was empty; throughput is 1 beat per cycle.
REQ-020 SHALL hold axis_out_tdata_o stable while axis_out_tvalid_o=1 and axis_out_tready_i=0.
REQ-021 SHALL decrement credit[c] when a data beat for channel c is pushed into the output FIFO.
REQ-022 SHALL increment credit[crd_idx] on each accepted axis_in beat with crd_vld=1.
REQ-023 SHALL leave credit[c] unchanged when a decrement and an increment for c occur in the same cycle.
REQ-024 SHALL, on a credit increment that would exceed RxDepth, saturate the counter and set err_o.
REQ-025 SHALL hold axis_in_tready_o=1 at all times outside reset; space at the receiver is guaranteed by the credits.
REQ-026 SHALL push data into RX FIFO dat_idx when an axis_in beat is accepted with dat_vld=1; noc_out_valid_o[c] SHALL be 1 while FIFO c is non-empty (1-cycle latency).
REQ-027 SHALL, when RX FIFO c is full on a push, drop the beat, set err_o, and leave the FIFO contents unchanged.
REQ-028 SHALL keep one pending-credit counter per channel (CntW bits) that increments on each noc_out handshake of channel c.
REQ-029 SHALL attach at most one credit return per outgoing beat: crd_vld=1, crd_idx = the lowest-index channel with pending>0, and that channel's pending counter decremented on the push.
REQ-030 SHALL, when no channel is eligible for TX but pending>0 and the output FIFO has space, push a credit-only beat (dat_vld=0, data=0).
REQ-031 SHALL net out simultaneous pending increment and decrement on the same channel.
REQ-032 SHALL drive crd_idx=0 when crd_vld=0, and dat_idx=0 when dat_vld=0.

Reset
REQ-033 SHALL, when rst_ni=0 at a rising edge, set: credits=RxDepth; pending=0; all FIFOs empty; round-robin pointer=0; err_o=0.
REQ-034 SHALL hold axis_out_tvalid_o, noc_out_valid_o, noc_in_ready_o and axis_in_tready_o at 0 while in reset.
REQ-035 SHALL discard any in-flight beats when reset is asserted mid-operation; no beat emitted before reset is replayed after it.

Verification (NumChan=2, DataWidth=32, RxDepth=4)
REQ-036 Single flit: ch1 sends 0xA5A50001, tready=1 -> next cycle beat dat_vld=1, dat_idx=1, data=0xA5A50001, crd_vld=0; credit[1]=3.
REQ-037 Credit exhaustion: ch0 holds valid for 5 flits with no returns -> 4 beats are sent, then noc_in_ready_o[0]=0; ch1 flits still pass.
REQ-038 Credit return: axis_in beat crd_vld=1, crd_idx=0 while ch0 is stalled -> credit[0] goes 0->1 and the 5th flit is sent.
REQ-039 Credit-only beats: 3 axis_in beats for ch1, then noc_out_ready_i[1]=1 with no TX traffic -> 3 beats with crd_vld=1, crd_idx=1, dat_vld=0 are emitted; pending[1] returns to 0.
REQ-040 Overflow: 5 axis_in data beats for ch0 with noc_out_ready_i=0 -> FIFO holds the first 4, the 5th is dropped, err_o=1 and stays 1 until reset.
REQ-041 Reset mid-traffic: reset asserted with the output FIFO full -> next cycle tvalid=0 and credits=4; after release a new flit emerges with correct fields.
